// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Register IDs are 4 bits wide, which fixes the register count at 16.
package wb_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int CNT_W    = 2;
    localparam int SEQ_W    = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot. It can drain and refill in the same cycle,
// and its ready output depends only on slot state, never on valid.
module wb_slot
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [REG_W-1:0]  reg_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEQ_W-1:0]  seq_i,
    input  logic              grant_i,
    output logic              ready_o,
    output logic              full_o,
    output logic [REG_W-1:0]  reg_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SEQ_W-1:0]  seq_o
);

    logic              full_q, full_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              load;

    assign ready_o = !full_q || grant_i;
    assign load    = valid_i && ready_o;

    always_comb begin
        full_d = full_q;
        reg_d  = reg_q;
        data_d = data_q;
        seq_d  = seq_q;
        if (grant_i) begin
            full_d = 1'b0;
        end
        if (load) begin
            full_d = 1'b1;
            reg_d  = reg_i;
            data_d = data_i;
            seq_d  = seq_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
            seq_q  <= '0;
        end else begin
            full_q <= full_d;
            reg_q  <= reg_d;
            data_q <= data_d;
            seq_q  <= seq_d;
        end
    end

    assign full_o = full_q;
    assign reg_o  = reg_q;
    assign data_o = data_q;
    assign seq_o  = seq_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and memory writeback paths,
// with age-then-round-robin arbitration and a per-register pending-write scoreboard.
module regfile_wb_arbiter
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_wb_valid,
    input  logic [REG_W-1:0]    alu_wb_reg,
    input  logic [DATA_W-1:0]   alu_wb_data,
    output logic                alu_wb_ready,
    input  logic                mem_wb_valid,
    input  logic [REG_W-1:0]    mem_wb_reg,
    input  logic [DATA_W-1:0]   mem_wb_data,
    output logic                mem_wb_ready,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_reg,
    output logic                issue_ready,
    output logic                rf_write_reg,
    output logic [REG_W-1:0]    rf_dst_reg,
    output logic [DATA_W-1:0]   rf_dst_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                sb_underflow
);

    logic              alu_full, mem_full;
    logic [REG_W-1:0]  alu_reg, mem_reg;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic [SEQ_W-1:0]  alu_seq, mem_seq;
    logic              grant_alu, grant_mem, contested;
    logic              alu_load, mem_load, alu_keep, mem_keep;

    // A slot waits at most two cycles, so a 2-bit load stamp never aliases.
    logic [SEQ_W-1:0]  cyc_q, cyc_d;
    req_e              rr_q, rr_d;
    logic              mem_older_q, mem_older_d;
    logic              sb_underflow_q, sb_underflow_d;

    wb_slot u_alu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (alu_wb_valid),
        .reg_i   (alu_wb_reg),
        .data_i  (alu_wb_data),
        .seq_i   (cyc_q),
        .grant_i (grant_alu),
        .ready_o (alu_wb_ready),
        .full_o  (alu_full),
        .reg_o   (alu_reg),
        .data_o  (alu_data),
        .seq_o   (alu_seq)
    );

    wb_slot u_mem_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (mem_wb_valid),
        .reg_i   (mem_wb_reg),
        .data_i  (mem_wb_data),
        .seq_i   (cyc_q),
        .grant_i (grant_mem),
        .ready_o (mem_wb_ready),
        .full_o  (mem_full),
        .reg_o   (mem_reg),
        .data_o  (mem_data),
        .seq_o   (mem_seq)
    );

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        contested = 1'b0;
        if (alu_full && mem_full) begin
            if (alu_seq == mem_seq) begin
                contested = 1'b1;
                if (rr_q == REQ_ALU) grant_alu = 1'b1;
                else                 grant_mem = 1'b1;
            end else if (mem_older_q) begin
                grant_mem = 1'b1;
            end else begin
                grant_alu = 1'b1;
            end
        end else if (alu_full) begin
            grant_alu = 1'b1;
        end else if (mem_full) begin
            grant_mem = 1'b1;
        end
    end

    always_comb begin
        rf_write_reg = grant_alu || grant_mem;
        rf_dst_reg   = '0;
        rf_dst_data  = '0;
        if (grant_alu) begin
            rf_dst_reg  = alu_reg;
            rf_dst_data = alu_data;
        end else if (grant_mem) begin
            rf_dst_reg  = mem_reg;
            rf_dst_data = mem_data;
        end
    end

    assign alu_load = alu_wb_valid && alu_wb_ready;
    assign mem_load = mem_wb_valid && mem_wb_ready;
    assign alu_keep = alu_full && !grant_alu;
    assign mem_keep = mem_full && !grant_mem;

    // Age flag only matters when the stamps differ; a same-cycle pair clears it.
    always_comb begin
        mem_older_d = mem_older_q;
        rr_d        = rr_q;
        cyc_d       = cyc_q + SEQ_W'(1);
        if (mem_keep && alu_load) begin
            mem_older_d = 1'b1;
        end else if (alu_keep && mem_load) begin
            mem_older_d = 1'b0;
        end else if (alu_load && mem_load) begin
            mem_older_d = 1'b0;
        end
        if (contested) begin
            rr_d = (rr_q == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end
    end

    logic                issue_fire;
    logic [NUM_REGS-1:0] cnt_sat;
    logic [NUM_REGS-1:0] uf_hit;

    assign issue_ready = !cnt_sat[issue_reg];
    assign issue_fire  = issue_valid && issue_ready;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
        logic             inc, dec;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        assign inc = issue_fire && (issue_reg == REG_W'(gi));
        assign dec = rf_write_reg && (rf_dst_reg == REG_W'(gi));

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (dec && !inc && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign uf_hit[gi]  = dec && !inc && (cnt_q == '0);
        assign cnt_sat[gi] = (cnt_q == CNT_MAX);
        assign busy[gi]    = (cnt_q != '0);
    end

    assign sb_underflow_d = sb_underflow_q || (|uf_hit);
    assign sb_underflow   = sb_underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q          <= '0;
            rr_q           <= REQ_ALU;
            mem_older_q    <= 1'b0;
            sb_underflow_q <= 1'b0;
        end else begin
            cyc_q          <= cyc_d;
            rr_q           <= rr_d;
            mem_older_q    <= mem_older_d;
            sb_underflow_q <= sb_underflow_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter: one row per cycle with the inputs
// driven that cycle and the outputs expected during that same cycle.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                alu_wb_valid, mem_wb_valid, issue_valid;
    logic [REG_W-1:0]    alu_wb_reg, mem_wb_reg, issue_reg;
    logic [DATA_W-1:0]   alu_wb_data, mem_wb_data;
    logic                alu_wb_ready, mem_wb_ready, issue_ready;
    logic                rf_write_reg;
    logic [REG_W-1:0]    rf_dst_reg;
    logic [DATA_W-1:0]   rf_dst_data;
    logic [NUM_REGS-1:0] busy;
    logic                sb_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] rf_model [NUM_REGS];

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_reg   (alu_wb_reg),
        .alu_wb_data  (alu_wb_data),
        .alu_wb_ready (alu_wb_ready),
        .mem_wb_valid (mem_wb_valid),
        .mem_wb_reg   (mem_wb_reg),
        .mem_wb_data  (mem_wb_data),
        .mem_wb_ready (mem_wb_ready),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .issue_ready  (issue_ready),
        .rf_write_reg (rf_write_reg),
        .rf_dst_reg   (rf_dst_reg),
        .rf_dst_data  (rf_dst_data),
        .busy         (busy),
        .sb_underflow (sb_underflow)
    );

    always #5 clk = ~clk;

    // The register file the block feeds.
    always @(posedge clk) begin
        if (rf_write_reg) rf_model[rf_dst_reg] <= rf_dst_data;
    end

    typedef struct {
        logic        iv;
        logic [3:0]  ir;
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic        e_we;
        logic [3:0]  e_reg;
        logic [15:0] e_data;
        logic        e_ar;
        logic        e_mr;
        logic [15:0] e_busy;
        logic        e_ir;
        logic        e_uf;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t v(input logic iv, input logic [3:0] ir,
                               input logic av, input logic [3:0] ar, input logic [15:0] ad,
                               input logic mv, input logic [3:0] mr, input logic [15:0] md,
                               input logic we, input logic [3:0] er, input logic [15:0] ed,
                               input logic ear, input logic emr, input logic [15:0] eb,
                               input logic eir, input logic euf);
        vec_t r;
        r.iv = iv; r.ir = ir; r.av = av; r.ar = ar; r.ad = ad;
        r.mv = mv; r.mr = mr; r.md = md;
        r.e_we = we; r.e_reg = er; r.e_data = ed; r.e_ar = ear; r.e_mr = emr;
        r.e_busy = eb; r.e_ir = eir; r.e_uf = euf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 0; issue_reg = 0;
        alu_wb_valid = 0; alu_wb_reg = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_reg = 0; mem_wb_data = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();

        //   iv ir  av ar ad        mv mr md        we er ed        ar mr busy      ir uf
        // Single ALU write to R3
        vecs.push_back(v(1,3, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        vecs.push_back(v(0,0, 1,3,16'hBEEF, 0,0,16'h0,    0,0,16'h0,    1,1,16'h0008, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,3,16'hBEEF, 1,1,16'h0008, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        // Same-cycle conflict, then a second pair that must grant MEM first
        vecs.push_back(v(1,1, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        vecs.push_back(v(1,2, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0002, 1,0));
        vecs.push_back(v(0,0, 1,1,16'h1111, 1,2,16'h2222, 0,0,16'h0,    1,1,16'h0006, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,1,16'h1111, 1,0,16'h0006, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,2,16'h2222, 1,1,16'h0004, 1,0));
        vecs.push_back(v(1,1, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        vecs.push_back(v(1,2, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0002, 1,0));
        vecs.push_back(v(0,0, 1,1,16'h1212, 1,2,16'h2121, 0,0,16'h0,    1,1,16'h0006, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,2,16'h2121, 0,1,16'h0006, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,1,16'h1212, 1,1,16'h0002, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        // Age ordering on R5
        vecs.push_back(v(1,5, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        vecs.push_back(v(1,5, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0020, 1,0));
        vecs.push_back(v(1,6, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0020, 1,0));
        vecs.push_back(v(0,0, 1,6,16'h6666, 1,5,16'hAAAA, 0,0,16'h0,    1,1,16'h0060, 1,0));
        vecs.push_back(v(0,0, 1,5,16'h5555, 0,0,16'h0,    1,6,16'h6666, 1,0,16'h0060, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,5,16'hAAAA, 0,1,16'h0020, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,5,16'h5555, 1,1,16'h0020, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        // Scoreboard saturation on R7
        vecs.push_back(v(1,7, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        vecs.push_back(v(1,7, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0080, 1,0));
        vecs.push_back(v(1,7, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0080, 1,0));
        vecs.push_back(v(1,7, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0080, 0,0));
        vecs.push_back(v(0,7, 1,7,16'h7001, 0,0,16'h0,    0,0,16'h0,    1,1,16'h0080, 0,0));
        vecs.push_back(v(0,7, 1,7,16'h7002, 0,0,16'h0,    1,7,16'h7001, 1,1,16'h0080, 0,0));
        vecs.push_back(v(0,7, 1,7,16'h7003, 0,0,16'h0,    1,7,16'h7002, 1,1,16'h0080, 1,0));
        vecs.push_back(v(0,7, 0,0,16'h0,    0,0,16'h0,    1,7,16'h7003, 1,1,16'h0080, 1,0));
        vecs.push_back(v(0,7, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,0));
        // Underflow on R9
        vecs.push_back(v(0,0, 0,0,16'h0,    1,9,16'h9999, 0,0,16'h0,    1,1,16'h0000, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    1,9,16'h9999, 1,1,16'h0000, 1,0));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,1));
        vecs.push_back(v(0,0, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,1));
        // Fill both slots ahead of the mid-stream reset
        vecs.push_back(v(1,4, 0,0,16'h0,    0,0,16'h0,    0,0,16'h0,    1,1,16'h0000, 1,1));
        vecs.push_back(v(0,0, 1,1,16'hAAA1, 1,2,16'hBBB2, 0,0,16'h0,    1,1,16'h0010, 1,1));

        // Reset state
        @(negedge clk);
        chk("reset_we",    32'(rf_write_reg), 32'd1 - 32'd1);
        chk("reset_reg",   32'(rf_dst_reg),   32'h0);
        chk("reset_data",  32'(rf_dst_data),  32'h0);
        chk("reset_aready",32'(alu_wb_ready), 32'h1);
        chk("reset_mready",32'(mem_wb_ready), 32'h1);
        chk("reset_busy",  32'(busy),         32'h0);
        chk("reset_iready",32'(issue_ready),  32'h1);
        chk("reset_uf",    32'(sb_underflow), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            issue_valid  = vecs[i].iv; issue_reg   = vecs[i].ir;
            alu_wb_valid = vecs[i].av; alu_wb_reg  = vecs[i].ar; alu_wb_data = vecs[i].ad;
            mem_wb_valid = vecs[i].mv; mem_wb_reg  = vecs[i].mr; mem_wb_data = vecs[i].md;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("row%0d_we", i),     32'(rf_write_reg), 32'(e.e_we));
            chk($sformatf("row%0d_reg", i),    32'(rf_dst_reg),   32'(e.e_reg));
            chk($sformatf("row%0d_data", i),   32'(rf_dst_data),  32'(e.e_data));
            chk($sformatf("row%0d_aready", i), 32'(alu_wb_ready), 32'(e.e_ar));
            chk($sformatf("row%0d_mready", i), 32'(mem_wb_ready), 32'(e.e_mr));
            chk($sformatf("row%0d_busy", i),   32'(busy),         32'(e.e_busy));
            chk($sformatf("row%0d_iready", i), 32'(issue_ready),  32'(e.e_ir));
            chk($sformatf("row%0d_uf", i),     32'(sb_underflow), 32'(e.e_uf));
            @(posedge clk);
            #1;
        end

        // Both slots now hold same-cycle writes; the round-robin pointer favours MEM.
        drive_idle();
        chk("prereset_we",  32'(rf_write_reg), 32'h1);
        chk("prereset_reg", 32'(rf_dst_reg),   32'h2);
        chk("prereset_data",32'(rf_dst_data),  32'hBBB2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_we",    32'(rf_write_reg), 32'h0);
        chk("midreset_reg",   32'(rf_dst_reg),   32'h0);
        chk("midreset_data",  32'(rf_dst_data),  32'h0);
        chk("midreset_aready",32'(alu_wb_ready), 32'h1);
        chk("midreset_mready",32'(mem_wb_ready), 32'h1);
        chk("midreset_busy",  32'(busy),         32'h0);
        chk("midreset_uf",    32'(sb_underflow), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postreset_we",   32'(rf_write_reg), 32'h0);
        chk("postreset_busy", 32'(busy),         32'h0);

        chk("rf_r3", 32'(rf_model[3]), 32'hBEEF);
        chk("rf_r5", 32'(rf_model[5]), 32'h5555);
        chk("rf_r7", 32'(rf_model[7]), 32'h7003);
        chk("rf_r9", 32'(rf_model[9]), 32'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 16×16-bit register file between two writeback requesters: the ALU path and the memory/load path. Each requester gets a one-entry holding slot with a valid/ready handshake. An age-then-round-robin arbiter commits at most one write per cycle. A per-register pending-write scoreboard gives the hazard unit `busy` flags. The block sits between the execute/memory stages and the register file's `write_reg`/`dst_reg`/`dst_data` inputs.

## Interface
- `NUM_REGS`, 16, architectural registers (fixed by the 4-bit register ID)
- `DATA_W`, 16, writeback data width
- `CNT_W`, 2, width of each per-register outstanding-write counter
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `alu_wb_valid`  in  1  ALU offers a write
- `alu_wb_reg`  in  4  ALU destination register
- `alu_wb_data`  in  16  ALU write data
- `alu_wb_ready`  out  1  ALU slot can accept this cycle
- `mem_wb_valid`, `mem_wb_reg`, `mem_wb_data`, `mem_wb_ready`: same as the ALU ports, for the memory path
- `issue_valid`  in  1  decode issues an instruction that will write `issue_reg`
- `issue_reg`  in  4  destination of the issued instruction
- `issue_ready`  out  1  the counter for `issue_reg` is below saturation
- `rf_write_reg`  out  1  write enable to the register file
- `rf_dst_reg`  out  4  register-file destination ID
- `rf_dst_data`  out  16  register-file write data
- `busy`  out  16  bit r set while register r has outstanding writes
- `sb_underflow`  out  1  sticky error: a write committed to a register whose count was 0

## Operation
**Slots**
- Each slot holds `full`, `reg`, `data` and a `seq` stamp.
- Accept: on `*_wb_valid && *_wb_ready`, the slot loads at the clock edge.
- `*_wb_ready = !full || grant_self`, so a slot can drain and refill in the same cycle.
- `ready` depends only on slot state, never on `valid`.

**Arbitration** (combinational, over full slots only)
- Exactly one slot full: that slot is granted.
- Both full, loaded in different cycles: the older slot wins (tracked by a 1-bit `mem_older` flag). This preserves program order for writes to the same register.
- Both full, loaded in the same cycle: the round-robin pointer decides. The pointer flips to the other requester after every contested grant.
- Reset pointer favours ALU.

**Commit**
- On a grant, `rf_write_reg=1`, and `rf_dst_reg`/`rf_dst_data` come from the granted slot.
- The slot clears at the edge unless it refills in the same cycle.
- With no grant, `rf_write_reg=0` and `rf_dst_reg`/`rf_dst_data` are 0.

**Scoreboard**
- One CNT_W-bit counter per register.
- Increments on `issue_valid && issue_ready` for `issue_reg`.
- Decrements on commit for `rf_dst_reg`.
- Increment and decrement of the same register in the same cycle: the count is unchanged.
- `issue_ready = (cnt[issue_reg] != 3)`. An issue with `issue_ready=0` is ignored.
- Decrement at count 0: the count stays 0, `sb_underflow` sets, and the write still commits.
- `busy[r] = (cnt[r] != 0)`. It is registered state, so it does not fall in the commit cycle; it falls the cycle after the last commit.

## Timing
- Reset values: slots empty, all counters 0, pointer = ALU, `mem_older=0`, `sb_underflow=0`.
  - Resulting outputs: `alu_wb_ready=mem_wb_ready=1`, `rf_write_reg=0`, `rf_dst_reg=0`, `rf_dst_data=0`, `busy=0`, `issue_ready=1`.
- Latency: a write accepted at edge N is presented with `rf_write_reg=1` during cycle N+1 (uncontended). The register file captures it at edge N+1.
- The register file's same-cycle bypass forwards `rf_dst_data` to readers during cycle N+1.
- Contended: the loser commits in cycle N+2. Its `ready` stays 0 through cycle N+1.
- Throughput: one commit per cycle total; a single uncontended requester can sustain one write per cycle.
- Reset asserted mid-operation: slots, counters and flags clear immediately. Pending writes are dropped and `rf_write_reg` drops asynchronously.

## Structure
- Shared package `wb_pkg` holds:
  - constants `NUM_REGS`, `REG_W=4`, `DATA_W`, `CNT_W`
  - requester enum `REQ_ALU=0`, `REQ_MEM=1`
- Natural sub-module: `wb_slot`, the one-entry holding buffer with `full`/ready logic, instantiated twice.
- Arbiter and scoreboard stay in the top level.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with both slots full. Required: `rf_write_reg=0` immediately, `busy=0`, both ready=1, `sb_underflow=0`.
- **Single ALU write:** issue R3, then ALU valid R3/0xBEEF. Required:
  - `busy[3]=1` the cycle after issue
  - next cycle `rf_write_reg=1`, `rf_dst_reg=3`, `rf_dst_data=0xBEEF`
  - `busy[3]=0` the cycle after the commit
- **Same-cycle conflict:** ALU R1/0x1111 and MEM R2/0x2222 both accepted at edge N. Required: ALU commits in N+1 and MEM in N+2; the next same-cycle pair grants MEM first.
- **Age ordering:** MEM R5/0xAAAA is loaded and stalled behind an ALU grant, then ALU R5/0x5555 arrives. Required: 0xAAAA commits before 0x5555, so R5 ends as 0x5555.
- **Scoreboard saturation:** issue R7 three times. Required: `issue_ready=0` for R7, and a 4th issue is ignored. Two commits to R7 in one cycle each give count 1 with `busy[7]=1`; a 3rd commit clears `busy[7]`.
- **Underflow:** MEM write to R9 with no prior issue. Required: the write commits, `sb_underflow=1` stays set until reset, and `busy[9]` stays 0.
